// File: rtl/clock_ctrl.sv
// HH:MM:SS timekeeping controller: 1 s prescaler, BCD carry chain and button-driven set mode.
// Optional 12-hour display with PM flag is enabled by defining CLOCK_CTRL_HOUR12_EN.
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic [1:0] state,
  output logic       blink,
  output logic       tick,
  output logic       pm
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
`ifdef CLOCK_CTRL_HOUR12_EN
  localparam logic [7:0] HR_RST = 8'h12;
`else
  localparam logic [7:0] HR_RST = 8'h00;
`endif

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_e;

  // Packed BCD {tens, ones} increment over 00..59.
  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Packed BCD hour increment; MSB flags a PM toggle.
  function automatic logic [8:0] inc_hour(input logic [7:0] v);
    logic [8:0] r;
`ifdef CLOCK_CTRL_HOUR12_EN
    if (v == 8'h12)             r = 9'h001;
    else if (v == 8'h11)        r = {1'b1, 8'h12};
    else if (v[3:0] == 4'd9)    r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                        r = {1'b0, v[7:4], v[3:0] + 4'd1};
`else
    if (v == 8'h23)             r = 9'h000;
    else if (v[3:0] == 4'd9)    r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                        r = {1'b0, v[7:4], v[3:0] + 4'd1};
`endif
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic             pm_q, pm_d, blink_q, blink_d, tick_q, tick_d;
  logic             tick_now;
  logic [8:0]       hr_inc;

  // Next-state logic: prescaler, time update and mode sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    pm_d     = pm_q;
    blink_d  = blink_q;
    tick_now = (cnt_q == CNT_MAX);
    hr_inc   = inc_hour(hr_q);

    unique case (state_q)
      ST_RUN: begin
        blink_d = 1'b0;
        // Full ripple carry: every digit commits on the same edge.
        if (tick_now) begin
          sec_d = inc_bcd60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = inc_bcd60(min_q);
            if (min_q == 8'h59) begin
              hr_d = hr_inc[7:0];
              pm_d = pm_q ^ hr_inc[8];
            end
          end
        end
        if (mode_btn) begin
          state_d = ST_SET_HR;
          blink_d = 1'b1;
        end
      end
      default: begin
        if (mode_btn) begin
          blink_d = 1'b1;
          unique case (state_q)
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default: begin
              state_d = ST_RUN;
              blink_d = 1'b0;
              cnt_d   = '0;
            end
          endcase
        end else begin
          if (tick_now) blink_d = ~blink_q;
          if (inc_btn) begin
            unique case (state_q)
              ST_SET_HR: begin
                hr_d = hr_inc[7:0];
                pm_d = pm_q ^ hr_inc[8];
              end
              ST_SET_MIN: min_d = inc_bcd60(min_q);
              default:    sec_d = inc_bcd60(sec_q);
            endcase
          end
        end
      end
    endcase

    tick_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= HR_RST;
      pm_q    <= 1'b0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pm_q    <= pm_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  assign sec_lo = sec_q[3:0];
  assign sec_hi = sec_q[7:4];
  assign min_lo = min_q[3:0];
  assign min_hi = min_q[7:4];
  assign hr_lo  = hr_q[3:0];
  assign hr_hi  = hr_q[7:4];
  assign state  = state_q;
  assign blink  = blink_q;
  assign tick   = tick_q;
  assign pm     = pm_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed scenarios plus random button traffic against a seconds-of-day model.
module tb_clock_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_btn, inc_btn;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic [1:0] state;
  logic       blink, tick, pm;
  logic [28:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: time as seconds since midnight, plus mode, blink and prescaler count.
  int m_t, m_state, m_presc;
  bit m_blink;

  clock_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .hr_lo(hr_lo), .hr_hi(hr_hi), .state(state), .blink(blink), .tick(tick), .pm(pm)
  );

  always #5 clk = ~clk;

  assign obs = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo, state, blink, tick, pm};

  function automatic logic [28:0] exp_vec();
    int h, mi, s, hd;
    bit p;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
`ifdef CLOCK_CTRL_HOUR12_EN
    hd = (h % 12 == 0) ? 12 : h % 12;
    p  = (h >= 12);
`else
    hd = h;
    p  = 1'b0;
`endif
    return {4'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            2'(m_state), m_blink, (m_presc == TD - 1), p};
  endfunction

  task automatic model_reset();
    m_t = 0; m_state = 0; m_presc = 0; m_blink = 1'b0;
  endtask

  task automatic model_step(input bit m, input bit i);
    bit tickc, clr;
    int h, mi, s;
    tickc = (m_presc == TD - 1);
    clr   = 1'b0;
    if (m_state == 0) begin
      if (tickc) m_t = (m_t + 1) % 86400;
      if (m) begin m_state = 1; m_blink = 1'b1; end
    end else if (m) begin
      m_state = (m_state + 1) % 4;
      m_blink = (m_state != 0);
      clr     = (m_state == 0);
    end else begin
      if (tickc) m_blink = !m_blink;
      if (i) begin
        h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
        case (m_state)
          1: h  = (h + 1) % 24;
          2: mi = (mi + 1) % 60;
          default: s = (s + 1) % 60;
        endcase
        m_t = h * 3600 + mi * 60 + s;
      end
    end
    m_presc = clr ? 0 : (m_presc + 1) % TD;
  endtask

  // One clock: drive buttons from a negedge, advance model at the posedge, return at next negedge.
  task automatic cyc(input bit m, input bit i);
    mode_btn = m;
    inc_btn  = i;
    @(posedge clk);
    model_step(m, i);
    @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_tick();
    int nt = 0;
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b0);
      if (tick) nt++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL tick_seq cycle %0d: got %h want %h", k, obs, exp_vec());
      end
      n_cmp++;
    end
    if (nt !== 3) begin
      n_fail++; $display("FAIL tick_count: got %0d want 3", nt);
    end
    n_cmp++;
  endtask

  task automatic test_preload_rollover();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 30 && (m_t / 3600) != 23; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 70 && ((m_t / 60) % 60) != 59; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 70 && (m_t % 60) != 58; k++) cyc(1'b0, 1'b1);
    if (obs !== exp_vec() || m_t != 86398) begin
      n_fail++; $display("FAIL preload_235958: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b0);
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL rollover cycle %0d: got %h want %h", k, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_set_hr();
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b0, 1'b1);
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL set_hr_inc %0d: got %h want %h", k, obs, exp_vec());
      end
      n_cmp++;
    end
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b0);
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL set_hr_frozen %0d: got %h want %h", k, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_set_min();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 70 && ((m_t / 60) % 60) != 59; k++) cyc(1'b0, 1'b1);
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL set_min_59: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
    cyc(1'b0, 1'b1);
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL set_min_wrap: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
    cyc(1'b1, 1'b1);
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL mode_inc_same_cycle: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_resume_and_async_reset();
    int n = 0;
    cyc(1'b1, 1'b0);
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL resume_run: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
    while (n < 10) begin
      cyc(1'b0, 1'b0);
      n++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL resume_cycle %0d: got %h want %h", n, obs, exp_vec());
      end
      n_cmp++;
      if (tick) break;
    end
    if (n !== TD - 1) begin
      n_fail++; $display("FAIL resume_tick_latency: got %0d edges want %0d", n, TD - 1);
    end
    n_cmp++;
    cyc(1'b0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_vec());
    end
    n_cmp++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    bit m, i;
    for (int k = 0; k < 600; k++) begin
      m = ($urandom_range(0, 19) == 0);
      i = ($urandom_range(0, 2) == 0);
      cyc(m, i);
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random cycle %0d: got %h want %h", k, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  initial begin
    reset    = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_tick();
    test_preload_rollover();
    test_set_hr();
    test_set_min();
    test_resume_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Timekeeping controller for the HH:MM:SS seven-segment clock.
- Divides clk into a 1-second tick and sequences the seconds, minutes and hours digit counters with correct carry chaining.
- Provides a button-driven set mode that edits one field at a time.
- Sits between the board push-button debouncers and the seven-segment digit mux.

Parameters:
TICK_DIV, 10, clk cycles per 1-second tick (board build overrides to the board clock frequency); minimum 2.

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
mode_btn  input  1  single-cycle pulse; advances the controller state
inc_btn  input  1  single-cycle pulse; increments the selected field in a set state
sec_lo  output  4  seconds ones digit, BCD 0-9
sec_hi  output  4  seconds tens digit, BCD 0-5
min_lo  output  4  minutes ones digit, BCD 0-9
min_hi  output  4  minutes tens digit, BCD 0-5
hr_lo  output  4  hours ones digit, BCD
hr_hi  output  4  hours tens digit, BCD
state  output  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
blink  output  1  blink phase for the field being edited; 0 in RUN
tick  output  1  one-cycle pulse at each 1-second boundary
pm  output  1  PM flag (see Optional Feature)

Behaviour:
Reset (reset=0, asynchronous), until the first posedge after release:
- all digits 0 (time 00:00:00)
- state=RUN
- prescaler=0, tick=0, blink=0, pm=0

Prescaler:
- counts 0..TICK_DIV-1 and wraps to 0.
- tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
- runs in every state.

RUN, on a tick cycle, all digit updates commit at the same edge (full ripple, no multi-cycle carry):
- sec_lo increments; 9 -> 0 with carry into sec_hi.
- sec_hi 5 -> 0 with carry into min_lo.
- min_lo / min_hi wrap the same way (9, 5), carrying into hours.
- hours 23 -> 00. Hours are treated as a 0-23 value split into hr_hi:hr_lo; 09 -> 10 and 19 -> 20 are handled.
- Result: 23:59:59 -> 00:00:00 in one edge.

Set states:
- Time is frozen; ticks do not advance digits.
- inc_btn increments only the selected field, modulo its range (hours 24, minutes 60, seconds 60), with no carry into the neighbouring field. Examples: 59 -> 00 for minutes; 23 -> 00 for hours.
- blink toggles on every tick and starts at 1 on entry to any set state.

State transitions, on mode_btn:
- RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
- Entering SET_HR: blink=1.
- SET_SEC -> RUN: prescaler cleared to 0, so the first tick after resuming occurs TICK_DIV cycles later; blink=0.

Simultaneous events:
- mode_btn and inc_btn in the same cycle: the mode transition happens and inc_btn is ignored.
- inc_btn in RUN: ignored.
- tick in the same cycle as mode_btn RUN -> SET_HR: the tick advance still commits, then time freezes.

Outputs: all registered and change only on clk edges or asynchronous reset.

Reset mid-operation: asserting reset in any state returns immediately to the reset values above.

Optional Feature:
Macro: CLOCK_CTRL_HOUR12_EN.

Defined (12-hour mode):
- Hours cycle 12, 01, 02 .. 11, 12; hour value 0 is never produced.
- Reset time is 12:00:00 with pm=0.
- pm toggles when the RUN carry takes the hours 11 -> 12 (i.e. 11:59:59 -> 12:00:00).
- In SET_HR, inc_btn steps hours 11 -> 12 and toggles pm at that step; 12 -> 01 does not toggle pm.

Undefined:
- 24-hour behaviour as specified above.
- pm tied to 0.

Test Plan:
1. TICK_DIV=4, release reset, wait 12 cycles -> tick pulses at cycles 4, 8, 12; time 00:00:03; state=0; blink=0.
2. Preload time 23:59:58 via set mode, run 2 ticks -> 23:59:59, then 00:00:00 in a single edge (all six digits change on the same edge).
3. mode_btn x1, then inc_btn x25 -> state=1, hours 01 (wrap 23 -> 00), minutes and seconds unchanged; time does not advance across ticks; blink toggles on each tick.
4. In SET_MIN at minutes 59, inc_btn -> minutes 00 with hours unchanged. Same cycle mode_btn+inc_btn -> state=3, minutes unchanged.
5. From SET_SEC, mode_btn -> state=0, prescaler=0, next tick exactly 4 cycles later; reset pulsed low mid-count -> all outputs 0 asynchronously, before the next clk edge.
6. With CLOCK_CTRL_HOUR12_EN, run from 11:59:59 pm=0 -> 12:00:00 pm=1; 12:59:59 -> 01:00:00 pm=1; reset -> 12:00:00 pm=0.
